// File: rtl/spram_be_pipe_if.sv
// Access bus for spram_be_pipe: request fields in,
// response data, response strobe and sweep status out.
interface spram_be_pipe_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LANE_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;

    logic                  ena;
    logic [NUM_LANES-1:0]  wea;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  read_valid;
    logic                  busy;

    modport master (
        output ena, wea, addr, din,
        input  dout, read_valid, busy
    );

    modport slave (
        input  ena, wea, addr, din,
        output dout, read_valid, busy
    );
endinterface

// File: rtl/spram_be_pipe.sv
// Single-port RAM with byte-lane writes, selectable
// read-during-write mode, optional output register and zero-fill sweep.
module spram_be_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int LANE_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int WRITE_MODE = 0,
    parameter int OUT_REG    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic clk,
    input  logic rst,
    spram_be_pipe_if.slave bus
);
    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nx;
    logic                  clr_we;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  acc;
    logic                  wr;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged;
    logic                  rsp_v;
    logic [DATA_WIDTH-1:0] rsp_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  rv_q;

    // sweep state and clear counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= (INIT_CLEAR != 0) ? CLEAR : RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // sweep sequencing: one zero write per cycle, leave after last word
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        clr_we   = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = 1'b1;
                cnt_nx = cnt + ADDR_WIDTH'(1);
                if (cnt == ADDR_WIDTH'(DEPTH - 1))
                    state_nx = RUN;
            end
            default: ;
        endcase
    end

    assign bus.busy = (state == CLEAR);
    assign acc      = (state == RUN) && bus.ena;
    assign wr       = acc && (|bus.wea);
    assign old_word = mem[bus.addr];

    // lane merge of write data over the stored word
    always_comb begin
        merged = old_word;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (bus.wea[i])
                merged[i*LANE_WIDTH +: LANE_WIDTH] =
                    bus.din[i*LANE_WIDTH +: LANE_WIDTH];
        end
    end

    // response selection for reads and read-during-write
    always_comb begin
        rsp_v = 1'b0;
        rsp_d = old_word;
        if (acc) begin
            if (!wr) begin
                rsp_v = 1'b1;
            end else begin
                case (WRITE_MODE)
                    1: begin
                        rsp_v = 1'b1;
                        rsp_d = merged;
                    end
                    2:       rsp_v = 1'b0;
                    default: rsp_v = 1'b1;
                endcase
            end
        end
    end

    // array update; reset leaves contents alone, the sweep zeroes them
    always_ff @(posedge clk) begin
        if (clr_we && rst)
            mem[cnt] <= '0;
        else if (wr)
            mem[bus.addr] <= merged;
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            logic                  st_v;
            logic [DATA_WIDTH-1:0] st_d;

            // extra response stage, flushed by reset
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    st_v   <= 1'b0;
                    st_d   <= '0;
                    rv_q   <= 1'b0;
                    dout_q <= '0;
                end else begin
                    st_v <= rsp_v;
                    if (rsp_v)
                        st_d <= rsp_d;
                    rv_q <= st_v;
                    if (st_v)
                        dout_q <= st_d;
                end
            end
        end else begin : g_direct
            // single response register, dout holds between responses
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rv_q   <= 1'b0;
                    dout_q <= '0;
                end else begin
                    rv_q <= rsp_v;
                    if (rsp_v)
                        dout_q <= rsp_d;
                end
            end
        end
    endgenerate

    assign bus.dout       = dout_q;
    assign bus.read_valid = rv_q;
endmodule

// File: tb/tb_spram_be_pipe.sv
// Bench for spram_be_pipe: four configurations share one stimulus
// stream and are compared against a word-level reference model.
module tb_spram_be_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic [1:0]  wea = '0;
    logic [3:0]  addr = '0;
    logic [15:0] din = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    spram_be_pipe_if b0 ();
    spram_be_pipe_if b1 ();
    spram_be_pipe_if b2 ();
    spram_be_pipe_if b3 ();

    assign b0.ena = ena; assign b0.wea = wea;
    assign b0.addr = addr; assign b0.din = din;
    assign b1.ena = ena; assign b1.wea = wea;
    assign b1.addr = addr; assign b1.din = din;
    assign b2.ena = ena; assign b2.wea = wea;
    assign b2.addr = addr; assign b2.din = din;
    assign b3.ena = ena; assign b3.wea = wea;
    assign b3.addr = addr; assign b3.din = din;

    spram_be_pipe #(.WRITE_MODE(0), .OUT_REG(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    spram_be_pipe #(.WRITE_MODE(1), .OUT_REG(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
    spram_be_pipe #(.WRITE_MODE(2), .OUT_REG(0)) u2 (.clk(clk), .rst(rst), .bus(b2));
    spram_be_pipe #(.WRITE_MODE(0), .OUT_REG(1)) u3 (.clk(clk), .rst(rst), .bus(b3));

    logic [15:0] dout_a [4];
    logic        rv_a   [4];
    logic        busy_a [4];
    assign dout_a[0] = b0.dout; assign rv_a[0] = b0.read_valid; assign busy_a[0] = b0.busy;
    assign dout_a[1] = b1.dout; assign rv_a[1] = b1.read_valid; assign busy_a[1] = b1.busy;
    assign dout_a[2] = b2.dout; assign rv_a[2] = b2.read_valid; assign busy_a[2] = b2.busy;
    assign dout_a[3] = b3.dout; assign rv_a[3] = b3.read_valid; assign busy_a[3] = b3.busy;

    // reference model: word array, sweep countdown, per-config response
    int          cfg_wm [4] = '{0, 1, 2, 0};
    int          cfg_or [4] = '{0, 0, 0, 1};
    logic [15:0] m_mem [16];
    int          m_clr;
    logic [15:0] e_d [4];
    logic        e_v [4];
    logic [15:0] s_d [4];
    logic        s_v [4];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_clr = 16;
        for (int k = 0; k < 4; k++) begin
            e_d[k] = '0; e_v[k] = 1'b0;
            s_d[k] = '0; s_v[k] = 1'b0;
        end
    endfunction

    function automatic void model_edge(logic e, logic [1:0] w, logic [3:0] a, logic [15:0] d);
        logic [15:0] oldw, neww, rd;
        logic        is_acc, is_wr, rv;
        is_acc = 1'b0;
        oldw = '0;
        neww = '0;
        if (m_clr > 0) begin
            m_mem[16 - m_clr] = '0;
            m_clr--;
        end else if (e) begin
            is_acc = 1'b1;
            oldw = m_mem[a];
            neww[7:0]  = w[0] ? d[7:0]  : oldw[7:0];
            neww[15:8] = w[1] ? d[15:8] : oldw[15:8];
        end
        is_wr = is_acc && (w != 2'b00);
        for (int k = 0; k < 4; k++) begin
            rv = is_acc;
            rd = oldw;
            if (is_wr && cfg_wm[k] == 1) rd = neww;
            if (is_wr && cfg_wm[k] == 2) rv = 1'b0;
            if (cfg_or[k] == 0) begin
                e_v[k] = rv;
                if (rv) e_d[k] = rd;
            end else begin
                e_v[k] = s_v[k];
                if (s_v[k]) e_d[k] = s_d[k];
                s_v[k] = rv;
                if (rv) s_d[k] = rd;
            end
        end
        if (is_wr) m_mem[a] = neww;
    endfunction

    function automatic void check_all();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("busy%0d", k), 32'(busy_a[k]), 32'(m_clr > 0));
            chk($sformatf("read_valid%0d", k), 32'(rv_a[k]), 32'(e_v[k]));
            chk($sformatf("dout%0d", k), 32'(dout_a[k]), 32'(e_d[k]));
        end
    endfunction

    // called at posedge+1; applies one access and checks after the edge
    task automatic step(input logic e, input logic [1:0] w,
                        input logic [3:0] a, input logic [15:0] d);
        ena = e; wea = w; addr = a; din = d;
        @(posedge clk);
        model_edge(e, w, a, d);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic count_busy(input string nm);
        int n;
        n = 0;
        while (busy_a[0] && n < 40) begin
            n++;
            step(1'b1, 2'b00, 4'd5, 16'hFFFF);
        end
        chk(nm, 32'(n), 32'd16);
    endtask

    typedef struct {
        logic        e;
        logic [1:0]  w;
        logic [3:0]  a;
        logic [15:0] d;
        logic [15:0] xd;
        logic        xv;
    } vec_t;

    vec_t tbl [16];

    initial begin
        tbl[0]  = '{1'b1, 2'b11, 4'd3, 16'hAABB, 16'h0000, 1'b1};
        tbl[1]  = '{1'b1, 2'b01, 4'd3, 16'h1122, 16'hAABB, 1'b1};
        tbl[2]  = '{1'b1, 2'b00, 4'd3, 16'h0000, 16'hAA22, 1'b1};
        tbl[3]  = '{1'b1, 2'b11, 4'd7, 16'h1234, 16'h0000, 1'b1};
        tbl[4]  = '{1'b1, 2'b11, 4'd7, 16'hBEEF, 16'h1234, 1'b1};
        tbl[5]  = '{1'b0, 2'b00, 4'd0, 16'h0000, 16'h1234, 1'b0};
        tbl[6]  = '{1'b1, 2'b00, 4'd7, 16'h0000, 16'hBEEF, 1'b1};
        tbl[7]  = '{1'b1, 2'b11, 4'd9, 16'h5A5A, 16'h0000, 1'b1};
        tbl[8]  = '{1'b1, 2'b00, 4'd9, 16'h0000, 16'h5A5A, 1'b1};
        for (int i = 9; i < 14; i++)
            tbl[i] = '{1'b0, 2'b00, 4'd9, 16'hFFFF, 16'h5A5A, 1'b0};
        tbl[14] = '{1'b1, 2'b10, 4'd9, 16'hFFFF, 16'h5A5A, 1'b1};
        tbl[15] = '{1'b1, 2'b00, 4'd9, 16'h0000, 16'hFF5A, 1'b1};

        for (int i = 0; i < 16; i++) m_mem[i] = 'x;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b1;

        count_busy("sweep_len");
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 2'b00, 4'(i), 16'h0);
            chk($sformatf("zero_%0d", i), 32'(dout_a[0]), 32'h0);
        end

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].e, tbl[i].w, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl_dout_%0d", i), 32'(dout_a[0]), 32'(tbl[i].xd));
            chk($sformatf("tbl_rv_%0d", i), 32'(rv_a[0]), 32'(tbl[i].xv));
            if (i == 4) begin
                chk("wf_dout", 32'(dout_a[1]), 32'hBEEF);
                chk("wf_rv", 32'(rv_a[1]), 32'd1);
                chk("nc_dout", 32'(dout_a[2]), 32'hAA22);
                chk("nc_rv", 32'(rv_a[2]), 32'd0);
            end
        end

        step(1'b1, 2'b11, 4'd0, 16'h000A);
        step(1'b1, 2'b11, 4'd1, 16'h000B);
        step(1'b1, 2'b11, 4'd2, 16'h000C);
        step(1'b0, 2'b00, 4'd0, 16'h0);
        step(1'b0, 2'b00, 4'd0, 16'h0);
        step(1'b1, 2'b00, 4'd0, 16'h0);
        chk("pipe_rv0", 32'(rv_a[3]), 32'd0);
        step(1'b1, 2'b00, 4'd1, 16'h0);
        chk("pipe_rv1", 32'(rv_a[3]), 32'd1);
        chk("pipe_d1", 32'(dout_a[3]), 32'h000A);
        step(1'b1, 2'b00, 4'd2, 16'h0);
        chk("pipe_rv2", 32'(rv_a[3]), 32'd1);
        chk("pipe_d2", 32'(dout_a[3]), 32'h000B);
        step(1'b0, 2'b00, 4'd0, 16'h0);
        chk("pipe_rv3", 32'(rv_a[3]), 32'd1);
        chk("pipe_d3", 32'(dout_a[3]), 32'h000C);
        step(1'b0, 2'b00, 4'd0, 16'h0);
        chk("pipe_rv4", 32'(rv_a[3]), 32'd0);
        chk("pipe_d4", 32'(dout_a[3]), 32'h000C);

        step(1'b1, 2'b00, 4'd1, 16'h0);
        do_reset();
        chk("flush_dout", 32'(dout_a[3]), 32'h0);
        count_busy("sweep_after_flush");
        chk("flush_dout_after", 32'(dout_a[3]), 32'h0);

        for (int i = 0; i < 8; i++)
            step(1'b1, 2'b00, 4'd5, 16'h0);
        do_reset();
        count_busy("sweep_restart");

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom),
                 4'($urandom), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/spram_be_pipe.md
Name: spram_be_pipe

Overview:
- Parametrised single-port synchronous RAM with per-lane byte-enable writes, selectable read-during-write mode and an optional output pipeline stage.
- After reset, a hardware sweep zero-fills the array, so that no single-cycle array clear is needed.
- Serves as the storage primitive under the FIFO and scratch buffers, and replaces the fixed-size 8-bit single-port RAM.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8, bits per write-enable lane.
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words (derived, not overridable).
- WRITE_MODE, 0, read-during-write behaviour: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.
- OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register (2-cycle latency).
- INIT_CLEAR, 1, 1 = zero-fill the array after reset; 0 = no sweep, array contents undefined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  access enable; sampled only when busy=0.
- wea  in  NUM_LANES (DATA_WIDTH/LANE_WIDTH)  per-lane write enable; all zeros with ena=1 is a read.
- addr  in  ADDR_WIDTH  word address.
- din  in  DATA_WIDTH  write data.
- dout  out  DATA_WIDTH  read data; holds its value between valid responses.
- read_valid  out  1  one-cycle pulse marking a new dout.
- busy  out  1  high while the zero-fill sweep is running; all accesses are ignored.

Behaviour:
- Reset (rst=0, asynchronous):
  - dout=0, read_valid=0, clear counter=0, pipeline stage cleared.
  - busy=1 if INIT_CLEAR=1, else busy=0.
  - The array itself is not touched by reset.
- FSM states: CLEAR, RUN.
  - Reset state is CLEAR if INIT_CLEAR=1, else RUN.
- CLEAR:
  - Each cycle writes 0 to ram[cnt], then cnt++.
  - The cycle that writes cnt=DEPTH-1 moves to RUN.
  - busy is high for exactly DEPTH cycles after reset release; it falls on the edge after the final write.
  - ena, wea, addr and din are ignored; read_valid stays 0.
  - Reset asserted mid-sweep restarts the sweep at cnt=0.
- RUN, with ena=0: no array access; read_valid=0; dout holds.
- RUN, read (ena=1, wea=0): dout <= ram[addr]; read_valid=1.
- RUN, write (ena=1, wea!=0):
  - For each lane i with wea[i]=1, ram[addr][lane i] <= din[lane i].
  - Lanes with wea[i]=0 keep their old contents.
  - Read-during-write result depends on WRITE_MODE:
    - READ_FIRST: dout <= old word; read_valid=1.
    - WRITE_FIRST: dout <= merged word (new lanes where wea=1, old lanes elsewhere); read_valid=1.
    - NO_CHANGE: dout holds; read_valid=0.
- Latency, OUT_REG=0: response visible in the cycle after the access edge.
- Latency, OUT_REG=1: response delayed one more cycle through a stage register.
  - dout and read_valid move together.
  - dout holds when no valid response arrives.
- Back-to-back accesses: one access per cycle, full throughput, no stalls.
- Responses emerge in issue order.
- Address space is exactly DEPTH, so there is no out-of-range case.
- An access issued in the last CLEAR cycle is ignored; the first honoured access is in the cycle busy=0 is first seen.
- Pipeline flush: an access issued just before reset is discarded; no read_valid appears after reset.

Test Plan (defaults unless stated):
- Sweep:
  - Stimulus: release reset; hold ena=1, wea=0, addr=5 throughout.
  - Required: busy high for exactly 16 cycles; read_valid=0 while busy; afterwards reads of every address return 0x0000.
- Byte enable:
  - Stimulus: write 0xAABB to addr 3 with wea=11; then write 0x1122 with wea=01; then read addr 3.
  - Required: dout=0xAA22 with read_valid=1 one cycle after the read.
- Write modes:
  - Stimulus: addr 7 holds 0x1234; write 0xBEEF to addr 7 with wea=11.
  - Required, WRITE_MODE=0: dout=0x1234, read_valid=1.
  - Required, WRITE_MODE=1: dout=0xBEEF, read_valid=1.
  - Required, WRITE_MODE=2: dout unchanged, read_valid=0.
- Pipeline, OUT_REG=1:
  - Stimulus: back-to-back reads of addr 0,1,2 holding 0x0A,0x0B,0x0C.
  - Required: read_valid high for 3 consecutive cycles, starting 2 cycles after the first read; dout=0x0A,0x0B,0x0C in order.
- Reset mid-operation:
  - Stimulus: assert rst at sweep cycle 8; release; wait.
  - Required: busy again high for a full 16 cycles.
  - Stimulus: assert rst with a read in flight (OUT_REG=1).
  - Required: no read_valid after release; dout=0.
- Idle hold:
  - Stimulus: read 0x5A5A; then ena=0 for 5 cycles.
  - Required: dout stays 0x5A5A; read_valid=0 on all 5 cycles.
